// File: rtl/data_mem_responder_pkg.sv
// Shared core constants: opcodes, ALU ops, load/store funct3 encodings,
// responder FSM states and the captured request payload.
package data_mem_responder_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmr_state_e;

  typedef struct packed {
    logic            write;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [2:0]      funct3;
  } mem_req_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channel between core and data memory.
interface data_mem_responder_if;
  logic        i_ReqValid;
  logic        o_ReqReady;
  logic        i_ReqWrite;
  logic [31:0] i_Addr;
  logic [31:0] i_WData;
  logic [2:0]  i_funct3;
  logic        o_RespValid;
  logic        i_RespReady;
  logic [31:0] o_RData;
  logic        o_RespErr;

  modport master (
    output i_ReqValid, i_ReqWrite, i_Addr, i_WData, i_funct3, i_RespReady,
    input  o_ReqReady, o_RespValid, o_RData, o_RespErr
  );

  modport slave (
    input  i_ReqValid, i_ReqWrite, i_Addr, i_WData, i_funct3, i_RespReady,
    output o_ReqReady, o_RespValid, o_RData, o_RespErr
  );
endinterface

// File: rtl/mem_lane_align.sv
// Size decode, byte-lane enables, store-data replication and load extension
// for RV32I loads/stores; purely combinational.
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        write_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic        size_err_c_o,
  output logic [3:0]  lane_en_c_o,
  output logic [31:0] wdata_lane_c_o,
  output logic [31:0] rdata_ext_c_o
);

  logic        legal_c;
  logic        misal_c;
  logic [31:0] shifted_c;

  assign shifted_c = rword_i >> {addr_lo_i, 3'b000};

  // Store data is replicated across lanes so the enables alone pick the target bytes
  always_comb begin
    legal_c        = 1'b0;
    misal_c        = 1'b0;
    lane_en_c_o    = 4'b0000;
    wdata_lane_c_o = wdata_i;
    rdata_ext_c_o  = 32'h0;
    case (funct3_i)
      F3_LB: begin
        legal_c        = 1'b1;
        lane_en_c_o    = 4'b0001 << addr_lo_i;
        wdata_lane_c_o = {4{wdata_i[7:0]}};
        rdata_ext_c_o  = {{24{shifted_c[7]}}, shifted_c[7:0]};
      end
      F3_LH: begin
        legal_c        = 1'b1;
        misal_c        = addr_lo_i[0];
        lane_en_c_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_lane_c_o = {2{wdata_i[15:0]}};
        rdata_ext_c_o  = {{16{shifted_c[15]}}, shifted_c[15:0]};
      end
      F3_LW: begin
        legal_c       = 1'b1;
        misal_c       = |addr_lo_i;
        lane_en_c_o   = 4'b1111;
        rdata_ext_c_o = rword_i;
      end
      F3_LBU: begin
        legal_c       = ~write_i;
        rdata_ext_c_o = {24'h0, shifted_c[7:0]};
      end
      F3_LHU: begin
        legal_c       = ~write_i;
        misal_c       = addr_lo_i[0];
        rdata_ext_c_o = {16'h0, shifted_c[15:0]};
      end
      default: ;
    endcase
  end

  assign size_err_c_o = ~legal_c | misal_c;

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering one load/store at a time after a
// fixed number of wait states, with misalignment/range/encoding errors.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                 i_Clk,
  input logic                 i_Reset,
  data_mem_responder_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  dmr_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  mem_req_t         req_q;
  logic             ready_q;
  logic             resp_valid_q;
  logic [31:0]      rdata_q;
  logic             resp_err_q;

  logic [31:0]      mem_q [DEPTH_WORDS];

  mem_req_t         cur_c;
  logic             accept_c;
  logic             enter_resp_c;
  logic             range_err_c;
  logic             size_err_c;
  logic             err_c;
  logic [IDX_W-1:0] idx_c;
  logic [31:0]      word_c;
  logic [3:0]       lane_en_c;
  logic [31:0]      wdata_lane_c;
  logic [31:0]      rdata_ext_c;
  logic [31:0]      load_data_c;
  logic [31:0]      wr_word_d;

  assign accept_c = bus.i_ReqValid & ready_q;

  // With zero wait states the request is resolved straight from the bus
  always_comb begin
    cur_c = req_q;
    if (state_q == ST_IDLE) begin
      cur_c.write  = bus.i_ReqWrite;
      cur_c.addr   = bus.i_Addr;
      cur_c.wdata  = bus.i_WData;
      cur_c.funct3 = bus.i_funct3;
    end
  end

  assign enter_resp_c = ((state_q == ST_IDLE) && accept_c && (WAIT_CYCLES == 0)) ||
                        ((state_q == ST_WAIT) && (cnt_q == '0));

  assign range_err_c = (cur_c.addr[31:2] >= 30'(DEPTH_WORDS));
  assign idx_c       = cur_c.addr[IDX_W+1:2];
  assign word_c      = mem_q[idx_c];

  mem_lane_align u_align (
    .funct3_i       (cur_c.funct3),
    .write_i        (cur_c.write),
    .addr_lo_i      (cur_c.addr[1:0]),
    .wdata_i        (cur_c.wdata),
    .rword_i        (word_c),
    .size_err_c_o   (size_err_c),
    .lane_en_c_o    (lane_en_c),
    .wdata_lane_c_o (wdata_lane_c),
    .rdata_ext_c_o  (rdata_ext_c)
  );

  assign err_c       = size_err_c | range_err_c;
  assign load_data_c = (err_c | cur_c.write) ? 32'h0 : rdata_ext_c;

  always_comb begin
    wr_word_d = word_c;
    for (int b = 0; b < 4; b++) begin
      if (lane_en_c[b]) wr_word_d[8*b +: 8] = wdata_lane_c[8*b +: 8];
    end
  end

  // Memory is never cleared; a reset edge also suppresses a commit
  always_ff @(posedge i_Clk) begin
    if (!i_Reset && enter_resp_c && cur_c.write && !err_c) begin
      mem_q[idx_c] <= wr_word_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            req_q   <= cur_c;
            ready_q <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              rdata_q      <= load_data_c;
              resp_err_q   <= err_c;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            rdata_q      <= load_data_c;
            resp_err_q   <= err_c;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus.i_RespReady) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0;
            resp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ReqReady  = ready_q;
  assign bus.o_RespValid = resp_valid_q;
  assign bus.o_RData     = rdata_q;
  assign bus.o_RespErr   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with two wait states, one with none.
module tb_data_mem_responder;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  data_mem_responder_if bus();
  data_mem_responder_if bus0();

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_w2 (
    .i_Clk(clk), .i_Reset(rst), .bus(bus)
  );

  data_mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_w0 (
    .i_Clk(clk), .i_Reset(rst), .bus(bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on the two-wait-state responder; inputs are scrambled after accept
  task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [2:0] f3, input int hold,
                     input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    int guard;
    guard = 0;
    while (bus.o_ReqReady !== 1'b1 && guard < 10) begin
      @(posedge clk); #1; guard++;
    end
    chk({tag, "_ready"}, 32'(bus.o_ReqReady), 32'd1);
    bus.i_ReqValid = 1'b1;
    bus.i_ReqWrite = wr;
    bus.i_Addr     = addr;
    bus.i_WData    = wd;
    bus.i_funct3   = f3;
    @(posedge clk); #1;
    bus.i_ReqValid = 1'b0;
    bus.i_ReqWrite = ~wr;
    bus.i_Addr     = ~addr;
    bus.i_WData    = ~wd;
    bus.i_funct3   = ~f3;
    lat = 1;
    while (bus.o_RespValid !== 1'b1 && lat < 16) begin
      chk({tag, "_busy"}, 32'(bus.o_ReqReady), 32'd0);
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_rdata"}, bus.o_RData, exp_rd);
    chk({tag, "_err"}, 32'(bus.o_RespErr), 32'(exp_err));
    chk({tag, "_noready"}, 32'(bus.o_ReqReady), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(bus.o_RespValid), 32'd1);
      chk({tag, "_hold_rdata"}, bus.o_RData, exp_rd);
      chk({tag, "_hold_ready"}, 32'(bus.o_ReqReady), 32'd0);
    end
    bus.i_RespReady = 1'b1;
    @(posedge clk); #1;
    bus.i_RespReady = 1'b0;
    chk({tag, "_idle_valid"}, 32'(bus.o_RespValid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(bus.o_ReqReady), 32'd1);
  endtask

  // One transaction on the zero-wait-state responder
  task automatic txn0(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [2:0] f3,
                      input logic [31:0] exp_rd, input logic exp_err);
    bus0.i_ReqValid = 1'b1;
    bus0.i_ReqWrite = wr;
    bus0.i_Addr     = addr;
    bus0.i_WData    = wd;
    bus0.i_funct3   = f3;
    @(posedge clk); #1;
    bus0.i_ReqValid = 1'b0;
    bus0.i_WData    = ~wd;
    chk({tag, "_valid_lat1"}, 32'(bus0.o_RespValid), 32'd1);
    chk({tag, "_ready_low"}, 32'(bus0.o_ReqReady), 32'd0);
    chk({tag, "_rdata"}, bus0.o_RData, exp_rd);
    chk({tag, "_err"}, 32'(bus0.o_RespErr), 32'(exp_err));
    bus0.i_RespReady = 1'b1;
    @(posedge clk); #1;
    bus0.i_RespReady = 1'b0;
    chk({tag, "_idle_ready"}, 32'(bus0.o_ReqReady), 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.i_ReqValid   = 1'b0; bus.i_ReqWrite  = 1'b0; bus.i_Addr  = '0;
    bus.i_WData      = '0;   bus.i_funct3    = '0;   bus.i_RespReady = 1'b0;
    bus0.i_ReqValid  = 1'b0; bus0.i_ReqWrite = 1'b0; bus0.i_Addr = '0;
    bus0.i_WData     = '0;   bus0.i_funct3   = '0;   bus0.i_RespReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.o_RespValid), 32'd0);
    chk("rst_rdata", bus.o_RData, 32'h0);
    chk("rst_err", 32'(bus.o_RespErr), 32'd0);
    rst = 1'b0;
    chk("rst_ready", 32'(bus.o_ReqReady), 32'd1);

    txn("sw_10",  1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 32'h0,        1'b0);
    txn("lw_10",  1'b0, 32'h10, 32'h0,        3'b010, 0, 32'hDEADBEEF, 1'b0);
    txn("sb_13",  1'b1, 32'h13, 32'h12345680, 3'b000, 0, 32'h0,        1'b0);
    txn("lb_13",  1'b0, 32'h13, 32'h0,        3'b000, 0, 32'hFFFFFF80, 1'b0);
    txn("lbu_13", 1'b0, 32'h13, 32'h0,        3'b100, 0, 32'h00000080, 1'b0);
    txn("lw_sb",  1'b0, 32'h10, 32'h0,        3'b010, 0, 32'h80ADBEEF, 1'b0);
    txn("lh_11",  1'b0, 32'h11, 32'h0,        3'b001, 0, 32'h0,        1'b1);
    txn("sw_12",  1'b1, 32'h12, 32'h11111111, 3'b010, 0, 32'h0,        1'b1);
    txn("lw_kept",1'b0, 32'h10, 32'h0,        3'b010, 0, 32'h80ADBEEF, 1'b0);
    txn("lw_100", 1'b0, 32'h100, 32'h0,       3'b010, 3, 32'h0,        1'b1);
    txn("f3_011", 1'b0, 32'h10, 32'h0,        3'b011, 0, 32'h0,        1'b1);
    txn("sbu_bad",1'b1, 32'h10, 32'h0,        3'b100, 0, 32'h0,        1'b1);
    txn("lh_12",  1'b0, 32'h12, 32'h0,        3'b001, 0, 32'hFFFF80AD, 1'b0);
    txn("lhu_12", 1'b0, 32'h12, 32'h0,        3'b101, 0, 32'h000080AD, 1'b0);
    txn("sh_10",  1'b1, 32'h10, 32'hAAAA5555, 3'b001, 0, 32'h0,        1'b0);
    txn("lw_sh",  1'b0, 32'h10, 32'h0,        3'b010, 0, 32'h80AD5555, 1'b0);
    txn("sw_fc",  1'b1, 32'hFC, 32'hA5A5A5A5, 3'b010, 0, 32'h0,        1'b0);
    txn("lw_fc",  1'b0, 32'hFC, 32'h0,        3'b010, 0, 32'hA5A5A5A5, 1'b0);
    txn("lw_hold",1'b0, 32'h10, 32'h0,        3'b010, 5, 32'h80AD5555, 1'b0);

    // Store interrupted by reset while waiting must not reach memory
    txn("sw_20",  1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 0, 32'h0,        1'b0);
    bus.i_ReqValid = 1'b1;
    bus.i_ReqWrite = 1'b1;
    bus.i_Addr     = 32'h20;
    bus.i_WData    = 32'h12345678;
    bus.i_funct3   = 3'b010;
    @(posedge clk); #1;
    bus.i_ReqValid = 1'b0;
    chk("wait_ready_low", 32'(bus.o_ReqReady), 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstw_valid", 32'(bus.o_RespValid), 32'd0);
    chk("rstw_ready", 32'(bus.o_ReqReady), 32'd1);
    txn("lw_20",  1'b0, 32'h20, 32'h0,        3'b010, 0, 32'hCAFEF00D, 1'b0);

    txn0("w0_sw3c", 1'b1, 32'h3C, 32'h0BADCAFE, 3'b010, 32'h0,        1'b0);
    txn0("w0_lw3c", 1'b0, 32'h3C, 32'h0,        3'b010, 32'h0BADCAFE, 1'b0);
    txn0("w0_lw40", 1'b0, 32'h40, 32'h0,        3'b010, 32'h0,        1'b1);
    txn0("w0_lhu3e",1'b0, 32'h3E, 32'h0,        3'b101, 32'h00000BAD, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 64, giving the number of 32-bit words stored (power of two).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the number of wait states between accept and response (0..15).
REQ-003 i_Clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 i_Reset  input  1  reset, synchronous and active-high.
REQ-005 i_ReqValid  input  1  the core presents a load/store request.
REQ-006 o_ReqReady  output  1  the responder can accept a request this cycle.
REQ-007 i_ReqWrite  input  1  1 = store, 0 = load.
REQ-008 i_Addr  input  32  byte address.
REQ-009 i_WData  input  32  store data, right-aligned.
REQ-010 i_funct3  input  3  access size/sign in RV32I load/store funct3 encoding.
REQ-011 o_RespValid  output  1  response available.
REQ-012 i_RespReady  input  1  the core accepts the response.
REQ-013 o_RData  output  32  load data, extended to 32 bits; 0 for stores and errors.
REQ-014 o_RespErr  output  1  the request was misaligned, out of range or illegal.

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT and RESP.
REQ-016 o_ReqReady SHALL be 1 only in IDLE; a request is accepted on a cycle with i_ReqValid=1 and o_ReqReady=1.
REQ-017 On accept, the block SHALL capture i_ReqWrite, i_Addr, i_WData and i_funct3; later changes on these inputs SHALL have no effect.
REQ-018 IDLE SHALL go to WAIT on accept when WAIT_CYCLES>0, and directly to RESP when WAIT_CYCLES=0.
REQ-019 In WAIT, a counter SHALL load WAIT_CYCLES-1 on accept and decrement each cycle; the FSM SHALL enter RESP on the cycle after the counter reaches 0.
REQ-020 Latency: o_RespValid SHALL rise exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-021 In RESP, o_RespValid, o_RData and o_RespErr SHALL stay stable until a cycle with i_RespReady=1; the FSM SHALL then return to IDLE.
REQ-022 o_ReqReady SHALL NOT be asserted in the same cycle as o_RespValid; there is no back-to-back overlap, so at most one request is outstanding.
REQ-023 Legal loads SHALL be 000 LB, 001 LH, 010 LW, 100 LBU and 101 LHU; legal stores SHALL be 000 SB, 001 SH and 010 SW; every other funct3 SHALL raise an error.
REQ-024 Misalignment SHALL raise an error: a halfword access with Addr[0]=1, or a word access with Addr[1:0]!=0.
REQ-025 A word index Addr[31:2] >= DEPTH_WORDS SHALL raise an error.
REQ-026 An errored request SHALL NOT modify memory and SHALL return o_RData=0 with o_RespErr=1.
REQ-027 A store SHALL commit on the edge entering RESP, using byte-lane enables derived from Addr[1:0]; only the enabled lanes change.
REQ-028 Loads SHALL read on the edge entering RESP; the selected byte or halfword SHALL be shifted to bit 0, sign-extended for LB/LH and zero-extended for LBU/LHU.
REQ-029 A store response SHALL have o_RData=0 and o_RespErr=0.
REQ-030 An error check SHALL be completed on the captured request; multiple error causes SHALL report one o_RespErr only.

Reset
REQ-031 While i_Reset=1 on a clock edge, the FSM SHALL go to IDLE, the counter SHALL clear to 0, o_RespValid SHALL be 0, o_RespErr SHALL be 0 and o_RData SHALL be 0.
REQ-032 o_ReqReady SHALL be 1 on the first cycle after reset deasserts.
REQ-033 Reset asserted while in WAIT SHALL drop the pending store without modifying memory; reset asserted in RESP SHALL discard the response.
REQ-034 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-035 The funct3 load/store encodings and the FSM state enum SHALL live in the shared package alongside the existing opcode/ALU constants.
REQ-036 Size decode, lane-enable generation and load extension SHALL be one combinational sub-module, mem_lane_align, reused by the core's load/store path.

Verification
REQ-037 SW 0xDEADBEEF to 0x10 followed by LW 0x10, WAIT_CYCLES=2 -> each response arrives 3 cycles after accept; o_RData=0xDEADBEEF; o_RespErr=0.
REQ-038 SB 0x80 to 0x13 followed by LB 0x13 and LBU 0x13 -> 0xFFFFFF80 then 0x00000080; LW 0x10 -> 0x80ADBEEF.
REQ-039 LH 0x11 and SW to 0x12 -> o_RespErr=1 and o_RData=0; a following LW 0x10 shows memory unchanged.
REQ-040 LW 0x100 with DEPTH_WORDS=64, and funct3=011 -> o_RespErr=1; o_ReqReady stays 0 until i_RespReady is accepted.
REQ-041 Hold i_RespReady=0 for 5 cycles in RESP -> o_RespValid and o_RData stay stable; IDLE is reached one cycle after i_RespReady=1.
REQ-042 Assert i_Reset during WAIT of SW 0x12345678 to 0x20 -> after reset, LW 0x20 returns the prior value; with WAIT_CYCLES=0 a response arrives 1 cycle after accept.
